// File: rtl/neuron_accumulator.sv
// Weighted-sum neuron stage: bias + sum(activation * weight) accumulated at full
// precision, then rounded (half toward +inf) and saturated to the signed output
// format consumed by sigmoid_function. One neuron in flight at a time.
module neuron_accumulator #(
    parameter int ACT_INT  = 1,
    parameter int ACT_FRAC = 9,
    parameter int W_INT    = 5,
    parameter int W_FRAC   = 5,
    parameter int OUT_INT  = 5,
    parameter int OUT_FRAC = 5,
    parameter int N_INPUTS = 8,
    parameter int ACC_W    = 26
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 c_en,
    input  logic                                 start,
    input  logic signed [W_INT+W_FRAC-1:0]       bias,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic        [ACT_INT+ACT_FRAC-1:0]   act_in,
    input  logic signed [W_INT+W_FRAC-1:0]       weight_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [OUT_INT+OUT_FRAC-1:0]   data_out,
    output logic                                 sat_flag,
    output logic                                 busy
);

    localparam int AW = ACT_INT + ACT_FRAC;
    localparam int WW = W_INT + W_FRAC;
    localparam int OW = OUT_INT + OUT_FRAC;
    localparam int PW = AW + WW + 1;
    // Right shift that brings the product fraction down to the output fraction.
    localparam int S  = ACT_FRAC + W_FRAC - OUT_FRAC;
    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    // Output clip limits, held at one bit wider than the accumulator.
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'sd1 <<< (OW-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic        [CW-1:0]     count_q;
    logic signed [OW-1:0]     data_q;
    logic                     out_valid_q;
    logic                     sat_q;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_sum_d;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    round_d;
    logic signed [OW-1:0]     data_d;
    logic                     sat_d;

    // Activation is unsigned, so a zero MSB is prepended before the signed multiply.
    assign prod      = PW'($signed({1'b0, act_in})) * PW'(weight_in);
    assign acc_sum_d = acc_q + ACC_W'(prod);

    // One extra headroom bit so adding the rounding half can never wrap.
    assign acc_ext = {acc_q[ACC_W-1], acc_q};

    generate
        if (S > 0) begin : g_round
            localparam logic signed [ACC_W:0] HALF = $signed((ACC_W+1)'(1) << (S-1));
            assign round_d = (acc_ext + HALF) >>> S;
        end else begin : g_no_round
            assign round_d = acc_ext;
        end
    endgenerate

    // Saturate the rounded sum into the output range and flag any clipping.
    always_comb begin
        data_d = round_d[OW-1:0];
        sat_d  = 1'b0;
        if (round_d > OUT_MAX) begin
            data_d = OUT_MAX[OW-1:0];
            sat_d  = 1'b1;
        end else if (round_d < OUT_MIN) begin
            data_d = OUT_MIN[OW-1:0];
            sat_d  = 1'b1;
        end
    end

    // Control FSM with all datapath and output registers; c_en=0 freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else if (c_en) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Align the bias binary point with the product binary point.
                        acc_q   <= ACC_W'(bias) <<< (ACT_FRAC + W_FRAC - W_FRAC);
                        count_q <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_q   <= acc_sum_d;
                        count_q <= count_q + CW'(1);
                        if (count_q == CW'(N_INPUTS - 1)) begin
                            state_q <= ROUND;
                        end
                    end
                end
                ROUND: begin
                    data_q      <= data_d;
                    sat_q       <= sat_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = c_en && (state_q == ACCUM);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign sat_flag  = sat_q;

endmodule
